// File: rtl/ddr3_rw_arb.sv
// MIG 7-series app_* sequencer: arbitrates write-FIFO and read-FIFO bursts with windowed address pointers.
// Build option: define DDR3_WR_PRIORITY_EN to make writes win every tie instead of round-robin.
module ddr3_rw_arb #(
    parameter int ADDR_W = 28,
    parameter int APP_DW = 128,
    parameter int CNT_W  = 10
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              init_calib_complete,
    input  logic              ddr3_read_valid,
    input  logic [ADDR_W-1:0] app_addr_wr_min,
    input  logic [ADDR_W-1:0] app_addr_wr_max,
    input  logic [ADDR_W-1:0] app_addr_rd_min,
    input  logic [ADDR_W-1:0] app_addr_rd_max,
    input  logic [7:0]        wr_bust_len,
    input  logic [7:0]        rd_bust_len,
    input  logic [CNT_W-1:0]  wfifo_rcount,
    input  logic [APP_DW-1:0] wfifo_dout,
    output logic              wfifo_rden,
    input  logic [CNT_W-1:0]  rfifo_wcount,
    output logic              rfifo_wren,
    output logic [APP_DW-1:0] rfifo_din,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [APP_DW-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [APP_DW-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    localparam int CMP_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WRITE, S_READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] win_min_q, win_min_d;
    logic [ADDR_W-1:0] win_max_q, win_max_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [7:0]        len_q, len_d;
    logic              last_rd_q, last_rd_d;
    logic              app_en_q, app_en_d;
    logic [2:0]        app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0] app_addr_q, app_addr_d;
    logic              wdf_wren_q, wdf_wren_d;
    logic              rfifo_wren_q, rfifo_wren_d;
    logic [APP_DW-1:0] rfifo_din_q, rfifo_din_d;

    logic [7:0] wr_len_eff, rd_len_eff;
    logic       wr_req, rd_req, grant_wr, grant_rd;
    logic       wr_beat, rd_beat;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] ptr,
                                                  input logic [ADDR_W-1:0] lo,
                                                  input logic [ADDR_W-1:0] hi);
        logic [ADDR_W:0] sum;
        sum = {1'b0, ptr} + (ADDR_W + 1)'(8);
        return (sum >= {1'b0, hi}) ? lo : sum[ADDR_W-1:0];
    endfunction

    // A zero length would otherwise never terminate the beat count.
    assign wr_len_eff = (wr_bust_len == 8'd0) ? 8'd1 : wr_bust_len;
    assign rd_len_eff = (rd_bust_len == 8'd0) ? 8'd1 : rd_bust_len;

    assign wr_req = CMP_W'(wfifo_rcount) >= CMP_W'(wr_len_eff);
    assign rd_req = ddr3_read_valid &&
                    ((CMP_W'(rfifo_wcount) + CMP_W'(rd_len_eff)) <= CMP_W'({CNT_W{1'b1}}));

    assign wr_beat = (state_q == S_WRITE) && app_rdy && app_wdf_rdy && !ui_clk_sync_rst;
    assign rd_beat = (state_q == S_READ) && app_rdy && !ui_clk_sync_rst;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        win_min_d    = win_min_q;
        win_max_d    = win_max_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        last_rd_d    = last_rd_q;
        app_en_d     = app_en_q;
        app_cmd_d    = app_cmd_q;
        app_addr_d   = app_addr_q;
        wdf_wren_d   = wdf_wren_q;
        rfifo_wren_d = app_rd_data_valid;
        rfifo_din_d  = app_rd_data;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (init_calib_complete) begin
                    state_d  = S_ARB;
                    wr_ptr_d = app_addr_wr_min;
                    rd_ptr_d = app_addr_rd_min;
                end
            end
            S_ARB: begin
                if (!init_calib_complete) begin
                    state_d = S_IDLE;
                end else begin
                    if (wr_req && rd_req) begin
`ifdef DDR3_WR_PRIORITY_EN
                        grant_wr = 1'b1;
`else
                        grant_wr = last_rd_q;
`endif
                    end else begin
                        grant_wr = wr_req;
                    end
                    grant_rd = rd_req && !grant_wr;

                    if (grant_wr) begin
                        state_d    = S_WRITE;
                        len_d      = wr_len_eff;
                        win_min_d  = app_addr_wr_min;
                        win_max_d  = app_addr_wr_max;
                        beat_cnt_d = 8'd0;
                        last_rd_d  = 1'b0;
                        app_en_d   = 1'b1;
                        app_cmd_d  = 3'b000;
                        app_addr_d = wr_ptr_q;
                        wdf_wren_d = 1'b1;
                    end else if (grant_rd) begin
                        state_d    = S_READ;
                        len_d      = rd_len_eff;
                        win_min_d  = app_addr_rd_min;
                        win_max_d  = app_addr_rd_max;
                        beat_cnt_d = 8'd0;
                        last_rd_d  = 1'b1;
                        app_en_d   = 1'b1;
                        app_cmd_d  = 3'b001;
                        app_addr_d = rd_ptr_q;
                    end
                end
            end
            S_WRITE: begin
                if (wr_beat) begin
                    wr_ptr_d   = ptr_next(wr_ptr_q, win_min_q, win_max_q);
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    app_addr_d = wr_ptr_d;
                    if (beat_cnt_q + 8'd1 == len_q) begin
                        state_d    = S_ARB;
                        app_en_d   = 1'b0;
                        wdf_wren_d = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (rd_beat) begin
                    rd_ptr_d   = ptr_next(rd_ptr_q, win_min_q, win_max_q);
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    app_addr_d = rd_ptr_d;
                    if (beat_cnt_q + 8'd1 == len_q) begin
                        state_d  = S_ARB;
                        app_en_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= app_addr_wr_min;
            rd_ptr_q     <= app_addr_rd_min;
            win_min_q    <= '0;
            win_max_q    <= '0;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            last_rd_q    <= 1'b1;
            app_en_q     <= 1'b0;
            app_cmd_q    <= '0;
            app_addr_q   <= '0;
            wdf_wren_q   <= 1'b0;
            rfifo_wren_q <= 1'b0;
            rfifo_din_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            win_min_q    <= win_min_d;
            win_max_q    <= win_max_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            last_rd_q    <= last_rd_d;
            app_en_q     <= app_en_d;
            app_cmd_q    <= app_cmd_d;
            app_addr_q   <= app_addr_d;
            wdf_wren_q   <= wdf_wren_d;
            rfifo_wren_q <= rfifo_wren_d;
            rfifo_din_q  <= rfifo_din_d;
        end
    end

    // The pop must coincide with the accepted beat so the FWFT word is fresh next cycle.
    assign wfifo_rden   = wr_beat;
    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_data = wfifo_dout;
    assign app_wdf_wren = wdf_wren_q;
    assign app_wdf_end  = wdf_wren_q;
    assign rfifo_wren   = rfifo_wren_q;
    assign rfifo_din    = rfifo_din_q;

endmodule
